// File: rtl/uart_line_framer_if.sv
// Handshake bundle between uart_line_framer, the line buffer and uart_send.
// slave = framer side, master = environment (line buffer + uart_send) side.
interface uart_line_framer_if #(
  parameter int H = 752,
  parameter int V = 480
);
  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam int LW = (V > 1) ? $clog2(V) : 1;

  logic          start;
  logic          line_ready;
  logic [7:0]    pixel_data;
  logic [LW-1:0] line_sel;
  logic [CW-1:0] column_sel;
  logic          release_line;
  logic [7:0]    tx_data;
  logic          tx_data_ready;
  logic          tx_idle;
  logic          busy;
  logic          frame_done;

  modport slave (
    input  start, line_ready, pixel_data, tx_idle,
    output line_sel, column_sel, release_line, tx_data, tx_data_ready,
           busy, frame_done
  );

  modport master (
    output start, line_ready, pixel_data, tx_idle,
    input  line_sel, column_sel, release_line, tx_data, tx_data_ready,
           busy, frame_done
  );
endinterface

// File: rtl/uart_line_framer.sv
// Frames each buffered image line as a UART packet: A5 5A LHI LLO PIX*H [CSUM].
// Optional per-line XOR checksum byte is enabled by defining LINE_FRAMER_CHECKSUM_EN.
module uart_line_framer #(
  parameter int H = 752,
  parameter int V = 480
) (
  input logic               clk_i,
  input logic               rst_i,
  uart_line_framer_if.slave bus
);
  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam int LW = (V > 1) ? $clog2(V) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(H - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WAIT_LINE = 4'd1;
  localparam logic [3:0] S_SYNC0     = 4'd2;
  localparam logic [3:0] S_SYNC1     = 4'd3;
  localparam logic [3:0] S_LHI       = 4'd4;
  localparam logic [3:0] S_LLO       = 4'd5;
  localparam logic [3:0] S_FETCH     = 4'd6;
  localparam logic [3:0] S_SEND_PIX  = 4'd7;
  localparam logic [3:0] S_LINE_END  = 4'd9;
`ifdef LINE_FRAMER_CHECKSUM_EN
  localparam logic [3:0] S_CSUM      = 4'd8;
`endif

  logic [3:0]    state_q, state_d;
  logic [LW-1:0] line_q, line_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    txd_q, txd_d;
  logic          txr_q, txr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rel_q, rel_d;
  logic          hold_q, hold_d;
`ifdef LINE_FRAMER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic [15:0]   line_idx;
  logic          send_en;
  logic [7:0]    byte_sel;
  logic [3:0]    nxt;

  assign line_idx = 16'(line_q);

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    col_d    = col_q;
    txd_d    = txd_q;
    txr_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rel_d    = rel_q;
    hold_d   = 1'b0;
`ifdef LINE_FRAMER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    send_en  = 1'b0;
    byte_sel = 8'h00;
    nxt      = state_q;

    case (state_q)
      S_IDLE: begin
        rel_d = 1'b1;
        // START landing on the FRAME_DONE cycle must not chain a new frame
        if (bus.start && !done_q) begin
          state_d = S_WAIT_LINE;
          busy_d  = 1'b1;
          rel_d   = 1'b0;
        end
      end
      S_WAIT_LINE: begin
        if (bus.line_ready) begin
          col_d   = '0;
`ifdef LINE_FRAMER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
          state_d = S_SYNC0;
        end
      end
      S_SYNC0: begin
        send_en  = 1'b1;
        byte_sel = 8'hA5;
        nxt      = S_SYNC1;
      end
      S_SYNC1: begin
        send_en  = 1'b1;
        byte_sel = 8'h5A;
        nxt      = S_LHI;
      end
      S_LHI: begin
        send_en  = 1'b1;
        byte_sel = line_idx[15:8];
        nxt      = S_LLO;
      end
      S_LLO: begin
        send_en  = 1'b1;
        byte_sel = line_idx[7:0];
        nxt      = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_SEND_PIX;
      end
      S_SEND_PIX: begin
        send_en  = 1'b1;
        byte_sel = bus.pixel_data;
        if (col_q != COL_LAST) begin
          nxt = S_FETCH;
        end else begin
`ifdef LINE_FRAMER_CHECKSUM_EN
          nxt = S_CSUM;
`else
          nxt = S_LINE_END;
`endif
        end
      end
`ifdef LINE_FRAMER_CHECKSUM_EN
      S_CSUM: begin
        send_en  = 1'b1;
        byte_sel = csum_q;
        nxt      = S_LINE_END;
      end
`endif
      S_LINE_END: begin
        col_d = '0;
        if (line_q != LINE_LAST) begin
          line_d  = line_q + LW'(1);
          rel_d   = 1'b0;
          state_d = S_WAIT_LINE;
        end else begin
          line_d  = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          rel_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // One-cycle holdoff covers the cycle before uart_send lowers TX_IDLE
    if (send_en && bus.tx_idle && !hold_q) begin
      txd_d   = byte_sel;
      txr_d   = 1'b1;
      hold_d  = 1'b1;
      state_d = nxt;
      if (state_q == S_SEND_PIX) begin
`ifdef LINE_FRAMER_CHECKSUM_EN
        csum_d = csum_q ^ bus.pixel_data;
`endif
        if (col_q != COL_LAST) begin
          col_d = col_q + CW'(1);
        end
      end
      if (nxt == S_LINE_END) begin
        rel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      col_q   <= '0;
      txd_q   <= 8'h00;
      txr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rel_q   <= 1'b1;
      hold_q  <= 1'b0;
`ifdef LINE_FRAMER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      col_q   <= col_d;
      txd_q   <= txd_d;
      txr_q   <= txr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
`ifdef LINE_FRAMER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.line_sel      = line_q;
  assign bus.column_sel    = col_q;
  assign bus.release_line  = rel_q;
  assign bus.tx_data       = txd_q;
  assign bus.tx_data_ready = txr_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = done_q;
endmodule

// File: doc/uart_line_framer.md
Name: uart_line_framer

Overview:
- Downstream consumer of the line buffer and upstream producer for uart_send.
- On a start request, walks the frame line by line. For each line it waits until the buffer holds the selected line, then reads it pixel by pixel.
- Each line is emitted as a framed UART packet: sync word, line index, H pixel bytes and an optional checksum.
- Replaces the ad-hoc send loop in the top level and gives the host a resynchronisable byte stream.

Parameters:
- H, 752, pixels per line. Sets the column counter width clog2(H).
- V, 480, lines per frame. Sets the line counter width clog2(V).

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request to send one frame. Ignored while BUSY=1.
- LINE_READY  in  1  line buffer reports that line LINE_SEL is fully captured.
- PIXEL_DATA  in  8  line buffer read data for address COLUMN_SEL. Valid 1 cycle after COLUMN_SEL changes.
- LINE_SEL  out  clog2(V)  line requested from the line buffer.
- COLUMN_SEL  out  clog2(H)  line buffer read address.
- RELEASE_LINE  out  1  clears the line buffer ready flag and lets it capture the next LINE_SEL.
- TX_DATA  out  8  byte to uart_send.
- TX_DATA_READY  out  1  one-cycle strobe; TX_DATA is valid in the same cycle.
- TX_IDLE  in  1  uart_send can accept a byte.
- BUSY  out  1  high from START acceptance until the last byte of line V-1 is strobed.
- FRAME_DONE  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset values:
  - State IDLE, LINE_SEL=0, COLUMN_SEL=0.
  - TX_DATA=0, TX_DATA_READY=0, BUSY=0, FRAME_DONE=0, checksum=0.
  - RELEASE_LINE=1.
- RST mid-frame aborts immediately to these values. No partial byte is strobed after RST.
- State IDLE:
  - RELEASE_LINE held 1.
  - START=1 → WAIT_LINE next cycle, with BUSY=1 and RELEASE_LINE=0.
- State WAIT_LINE:
  - LINE_READY is sampled only in this state.
  - When 1: COLUMN_SEL=0, checksum cleared, → SYNC0.
- Byte emit rule, applied to every send state:
  - A byte is strobed only when TX_IDLE=1 and the holdoff flag is clear.
  - The strobe sets holdoff for exactly one cycle, because uart_send drops TX_IDLE one cycle after the strobe.
  - At most one strobe per 2 cycles.
- Byte order per line:
  - SYNC0 = 0xA5, then SYNC1 = 0x5A.
  - LHI = line index zero-extended to 16 bits, bits [15:8]; LLO = bits [7:0].
  - PIX × H, column 0 first.
- Pixel fetch:
  - Before each pixel, state FETCH spends one cycle so PIXEL_DATA matches COLUMN_SEL.
  - In SEND_PIX, once PIXEL_DATA is strobed: checksum ^= PIXEL_DATA.
  - If COLUMN_SEL≠H-1: COLUMN_SEL+1 and → FETCH.
  - Otherwise → CSUM, or → LINE_END when the optional feature is off.
- LINE_END (one cycle):
  - RELEASE_LINE=1 for exactly this cycle, COLUMN_SEL=0.
  - If LINE_SEL≠V-1: LINE_SEL+1, → WAIT_LINE.
  - Otherwise: LINE_SEL=0, FRAME_DONE=1, BUSY=0, → IDLE.
- Counter arithmetic wraps in its own width. No H or V compare is ever made outside 0..H-1 or 0..V-1.
- Simultaneous events:
  - START during BUSY is dropped, not queued.
  - START in the same cycle as FRAME_DONE is ignored. A new frame needs START while state is IDLE.
- Bytes per line = 4 + H (+1 with checksum). Bytes per frame = V × that.

Optional Feature:
- Macro LINE_FRAMER_CHECKSUM_EN.
- Defined: after the last pixel, state CSUM strobes one byte equal to the XOR of all H pixel bytes of that line; header bytes are excluded. The checksum register is cleared in WAIT_LINE.
- Undefined: no CSUM state and no checksum register; LINE_END follows the last pixel directly. All other timing is unchanged.

Test Plan:
1. H=4, V=3, LINE_READY tied 1, TX_IDLE tied 1, PIXEL_DATA = 0x10+COLUMN_SEL, pulse START:
   - Line 0 bytes A5 5A 00 00 10 11 12 13, plus 00 with checksum enabled.
   - 24 bytes (27 with checksum) per frame.
   - FRAME_DONE pulses once, then BUSY=0, LINE_SEL=0.
2. Hold LINE_READY=0 for 50 cycles after START:
   - No TX_DATA_READY strobe and RELEASE_LINE=0 throughout.
   - First strobe (A5) no earlier than 1 cycle after LINE_READY rises.
3. uart model drops TX_IDLE for 10 cycles after each strobe:
   - Strobes spaced at least 11 cycles apart.
   - No byte lost or duplicated; sequence identical to test 1.
4. Assert RST during the pixel bytes of line 1:
   - Next cycle: BUSY=0, TX_DATA_READY=0, LINE_SEL=0, RELEASE_LINE=1.
   - A fresh START restarts from line 0 with A5.
5. Pulse START again mid-frame and in the FRAME_DONE cycle:
   - Total byte count stays exactly one frame.
   - A START two cycles after FRAME_DONE begins a second frame.
6. H=752, V=480 with checksum enabled: line 479 header is 01 DF; RELEASE_LINE pulses exactly 480 times, plus the level-high idle periods.
